// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration controller.
// Holds the coordinate-system and FSM encodings plus the hyperbolic repeat points.
// Pure declarations; no logic, no latency, no flow control.
package cordic_pkg;

  localparam int IDX_W_DEF = 6;

  // Hyperbolic CORDIC only converges if these shift amounts are issued twice.
  localparam int REP_A = 4;
  localparam int REP_B = 13;
  localparam int REP_C = 40;

  // Bit 1 set means hyperbolic, so 2'b11 is also treated as hyperbolic.
  typedef enum logic [1:0] {
    CIRC = 2'b00,
    LIN  = 2'b01,
    HYP  = 2'b10
  } cs_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic is_rep(input int unsigned v);
    return (v == REP_A) || (v == REP_B) || (v == REP_C);
  endfunction

endpackage

// File: rtl/cordic_iter_gen.sv
// Shift-index sequencer: emits the per-iteration shift amount and the last-iteration flag.
// init loads the first index on the same edge as the accept; each step advances on the next edge.
// No handshake of its own; the controller only steps it during iteration cycles.
module cordic_iter_gen
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             init_i,
  input  logic             hyp_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] shift_idx_o,
  output logic             last_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hyp_q, hyp_d;
  logic             rep_q, rep_d;   // current index has already been issued once
  logic             rep_now;

  // A hyperbolic repeat point is pending until it has been issued a second time.
  always_comb begin
    rep_now = hyp_q && is_rep(32'(idx_q)) && !rep_q;
    last_o  = (idx_q == LAST_IDX) && !rep_now;
  end

  // Next index: load first value on init, hold on a pending repeat, stop at the end (no wrap).
  always_comb begin
    idx_d = idx_q;
    hyp_d = hyp_q;
    rep_d = rep_q;
    if (init_i) begin
      idx_d = hyp_i ? IDX_W'(1) : '0;
      hyp_d = hyp_i;
      rep_d = 1'b0;
    end else if (step_i && !last_o) begin
      if (rep_now) begin
        rep_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        rep_d = 1'b0;
      end
    end
  end

  // Sequencer state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      idx_q <= '0;
      hyp_q <= 1'b0;
      rep_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      hyp_q <= hyp_d;
      rep_q <= rep_d;
    end
  end

  assign shift_idx_o = idx_q;

endmodule

// File: rtl/cordic_ctrl.sv
// CORDIC controller: sequences load, N micro-rotations and result hand-off to a datapath.
// Latency: accept at T -> dp_load at T+1, K dp_en cycles, res_valid at T+2+K.
// Backpressure: start_ready only in IDLE; result held in DONE until res_ready or abort.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       coordinate_system,
  input  logic             mode,
  input  logic             abort,
  output logic             dp_load,
  output logic             dp_en,
  output logic             dp_last,
  output logic [IDX_W-1:0] shift_idx,
  output logic [IDX_W-1:0] lut_addr,
  output logic [1:0]       cs_q,
  output logic             mode_q,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready
);

  state_e     state_q, state_d;
  logic [1:0] cs_d;
  logic       mode_d;
  logic       accept;
  logic       iter_last;

  assign start_ready = (state_q == IDLE) && rst;
  assign accept      = start_valid && start_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort only matters once an operation is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: state_d = abort ? IDLE : ITER;
      ITER: begin
        if (abort)          state_d = IDLE;
        else if (iter_last) state_d = DONE;
      end
      DONE: if (abort || res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    dp_load   = (state_q == LOAD);
    dp_en     = (state_q == ITER);
    dp_last   = (state_q == ITER) && iter_last;
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Operation attributes change only when an operation is accepted.
  always_comb begin
    cs_d   = accept ? coordinate_system : cs_q;
    mode_d = accept ? mode : mode_q;
  end

  // Latched operation attributes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_q   <= 2'b00;
      mode_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      mode_q <= mode_d;
    end
  end

  cordic_iter_gen #(
    .N_ITER (N_ITER),
    .IDX_W  (IDX_W)
  ) u_iter_gen (
    .clk_i       (clk),
    .rst_n_i     (rst),
    .init_i      (accept),
    .hyp_i       (coordinate_system[1]),
    .step_i      (dp_en),
    .shift_idx_o (shift_idx),
    .last_o      (iter_last)
  );

  // The angle table is indexed by the same value as the shifter.
  assign lut_addr = shift_idx;

endmodule

// File: tb/tb_cordic_ctrl.sv
module tb_cordic_ctrl;
  import cordic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_valid, abort, res_ready, mode;
  logic [1:0] cs_in;

  logic       r16, l16, e16, t16, m16, b16, v16;
  logic [5:0] s16, a16;
  logic [1:0] c16;
  logic       r48, l48, e48, t48, m48, b48, v48;
  logic [5:0] s48, a48;
  logic [1:0] c48;

  cordic_ctrl #(.N_ITER(16), .IDX_W(6)) dut16 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(r16),
    .coordinate_system(cs_in), .mode(mode), .abort(abort),
    .dp_load(l16), .dp_en(e16), .dp_last(t16), .shift_idx(s16), .lut_addr(a16),
    .cs_q(c16), .mode_q(m16), .busy(b16), .res_valid(v16), .res_ready(res_ready));

  cordic_ctrl #(.N_ITER(48), .IDX_W(6)) dut48 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(r48),
    .coordinate_system(cs_in), .mode(mode), .abort(abort),
    .dp_load(l48), .dp_en(e48), .dp_last(t48), .shift_idx(s48), .lut_addr(a48),
    .cs_q(c48), .mode_q(m48), .busy(b48), .res_valid(v48), .res_ready(res_ready));

  bit sel48 = 1'b0;
  logic       o_ready, o_load, o_en, o_last, o_mode, o_busy, o_valid;
  logic [5:0] o_shift, o_lut;
  logic [1:0] o_cs;
  assign o_ready = sel48 ? r48 : r16;
  assign o_load  = sel48 ? l48 : l16;
  assign o_en    = sel48 ? e48 : e16;
  assign o_last  = sel48 ? t48 : t16;
  assign o_shift = sel48 ? s48 : s16;
  assign o_lut   = sel48 ? a48 : a16;
  assign o_cs    = sel48 ? c48 : c16;
  assign o_mode  = sel48 ? m48 : m16;
  assign o_busy  = sel48 ? b48 : b16;
  assign o_valid = sel48 ? v48 : v16;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic [1:0] last_cs = 2'b00;
  logic       last_md = 1'b0;

  // Reference sequence: plain list of shift amounts from the algorithm's rules.
  task automatic build_exp(input int n, input bit hyp);
    exp_q.delete();
    for (int k = (hyp ? 1 : 0); k < n; k++) begin
      exp_q.push_back(k);
      if (hyp && (k == 4 || k == 13 || k == 40)) exp_q.push_back(k);
    end
  endtask

  function automatic int seq_len(input int n, input bit hyp);
    int c = 0;
    for (int k = (hyp ? 1 : 0); k < n; k++) begin
      c++;
      if (hyp && (k == 4 || k == 13 || k == 40)) c++;
    end
    return c;
  endfunction

  task automatic idle_all();
    @(negedge clk);
    start_valid = 1'b0; res_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Offers an operation at a negedge and returns at the negedge of the LOAD cycle.
  task automatic start_op(input logic [1:0] cs, input logic md);
    start_valid = 1'b1; cs_in = cs; mode = md;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready_idle: got %b want 1", o_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
    cs_in = 2'($urandom_range(0, 3)); mode = 1'($urandom_range(0, 1));
    last_cs = cs; last_md = md;
    checks++;
    if ({o_load, o_en, o_busy, o_ready, o_valid} !== 5'b10100) begin
      errors++; $display("FAIL load_cycle: load/en/busy/ready/valid=%b want 10100",
                         {o_load, o_en, o_busy, o_ready, o_valid});
    end
    checks++;
    if (o_shift !== 6'(exp_q[0]) || o_lut !== 6'(exp_q[0]) || o_cs !== cs || o_mode !== md) begin
      errors++; $display("FAIL load_attrs: shift=%0d lut=%0d cs=%b mode=%b want shift=%0d cs=%b mode=%b",
                         o_shift, o_lut, o_cs, o_mode, exp_q[0], cs, md);
    end
  endtask

  // Follows the iterations, checks latency/sequence/last flag, then the DONE handshake.
  task automatic finish_op(input logic [1:0] cs, input logic md, input int rdelay, input bit use_abort);
    int k = exp_q.size();
    int n_it = 0, n_last = 0, last_pos = -1, c = 0;
    bit seq_ok = 1'b1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (o_valid === 1'b1) break;
      if (o_load !== 1'b0) seq_ok = 1'b0;
      if (o_en === 1'b1) begin
        if (o_last === 1'b1) begin n_last++; last_pos = n_it; end
        if (n_it >= k || o_shift !== 6'(exp_q[n_it]) || o_lut !== o_shift) seq_ok = 1'b0;
        n_it++;
      end else if (o_last !== 1'b0) seq_ok = 1'b0;
    end
    checks++;
    if (c != k + 1 || o_valid !== 1'b1) begin
      errors++; $display("FAIL latency: res_valid after %0d cycles from LOAD want %0d", c, k + 1);
    end
    checks++;
    if (n_it != k || !seq_ok) begin
      errors++; $display("FAIL sequence: %0d iteration cycles (ok=%0d) want %0d", n_it, seq_ok, k);
    end
    checks++;
    if (n_last != 1 || last_pos != k - 1) begin
      errors++; $display("FAIL dp_last: count=%0d pos=%0d want 1 at %0d", n_last, last_pos, k - 1);
    end
    for (int i = 0; i < rdelay; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b1 || o_en !== 1'b0 ||
          o_shift !== 6'(exp_q[k-1]) || o_cs !== cs || o_mode !== md) begin
        errors++; $display("FAIL done_hold: cyc=%0d valid=%b ready=%b shift=%0d cs=%b mode=%b",
                           i, o_valid, o_ready, o_shift, o_cs, o_mode);
      end
      if (i == rdelay - 1) begin
        res_ready = 1'b1; abort = use_abort;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    res_ready = 1'b0; abort = 1'b0;
    checks++;
    if ({o_busy, o_valid, o_ready} !== 3'b001) begin
      errors++; $display("FAIL back_to_idle: busy/valid/ready=%b want 001", {o_busy, o_valid, o_ready});
    end
  endtask

  task automatic run_op(input logic [1:0] cs, input logic md, input int rdelay, input bit use_abort);
    idle_all();
    build_exp(sel48 ? 48 : 16, cs[1]);
    start_op(cs, md);
    finish_op(cs, md, rdelay, use_abort);
  endtask

  task automatic test_reset();
    rst = 1'b0; start_valid = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel48 = d[0];
      #1;
      checks++;
      if ({o_ready, o_load, o_en, o_last, o_busy, o_valid, o_mode, o_cs, o_shift, o_lut} !== '0) begin
        errors++; $display("FAIL reset_state dut%0d: ready=%b load=%b en=%b busy=%b valid=%b cs=%b shift=%0d want all 0",
                           d, o_ready, o_load, o_en, o_busy, o_valid, o_cs, o_shift);
      end
    end
    sel48 = 1'b0;
    start_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_circular();
    run_op(2'b00, 1'b0, 1, 1'b0);
  endtask

  task automatic test_random_ops();
    repeat (8) run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_hyperbolic();
    run_op(2'b10, 1'b1, 1, 1'b0);
    sel48 = 1'b1;
    run_op(2'b11, 1'b0, 2, 1'b0);
    run_op(2'b01, 1'b1, 1, 1'b0);
    sel48 = 1'b0;
  endtask

  task automatic test_done_hold();
    run_op(2'b00, 1'b1, 5, 1'b0);
  endtask

  task automatic test_abort_iter();
    bit seen = 1'b0;
    idle_all();
    build_exp(16, 1'b0);
    start_op(2'b00, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (o_en !== 1'b1 || o_shift !== 6'd2) begin
      errors++; $display("FAIL abort_third_iter: en=%b shift=%0d want 1 2", o_en, o_shift);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({o_en, o_load, o_busy, o_valid, o_ready} !== 5'b00001) begin
      errors++; $display("FAIL abort_effect: en/load/busy/valid/ready=%b want 00001",
                         {o_en, o_load, o_busy, o_valid, o_ready});
    end
    repeat (25) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || o_en !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_no_result: activity after abort got 1 want 0");
    end
  endtask

  task automatic test_abort_with_start();
    idle_all();
    build_exp(16, 1'b1);
    abort = 1'b1;
    start_op(2'b10, 1'b0);
    abort = 1'b0;
    finish_op(2'b10, 1'b0, 1, 1'b0);
  endtask

  task automatic test_abort_in_done();
    run_op(2'b01, 1'b0, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    idle_all();
    build_exp(16, 1'b0);
    start_op(2'b01, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_ready, o_load, o_en, o_last, o_busy, o_valid, o_mode, o_cs, o_shift, o_lut} !== '0) begin
      errors++; $display("FAIL reset_mid: ready=%b en=%b busy=%b valid=%b cs=%b mode=%b shift=%0d want all 0",
                         o_ready, o_en, o_busy, o_valid, o_cs, o_mode, o_shift);
    end
    rst = 1'b1;
    start_op(2'b01, 1'b0);
    finish_op(2'b01, 1'b0, 1, 1'b0);
  endtask

  // Timeline model: LOAD, K iterations, one DONE cycle, one IDLE cycle, then the next accept.
  task automatic test_back_to_back();
    bit         m_idle = 1'b1;
    int         t = 0, k = 0, bad = 0;
    logic [1:0] m_cs = last_cs;
    logic       m_md = last_md;
    idle_all();
    start_valid = 1'b1; res_ready = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      checks++;
      if (o_ready !== m_idle || o_cs !== m_cs || o_mode !== m_md ||
          o_valid !== (!m_idle && t == k + 1)) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL back_to_back cyc=%0d: ready=%b cs=%b mode=%b valid=%b want %b %b %b %b",
                   cyc, o_ready, o_cs, o_mode, o_valid, m_idle, m_cs, m_md, (!m_idle && t == k + 1));
      end
      cs_in = 2'($urandom_range(0, 3)); mode = 1'($urandom_range(0, 1));
      if (m_idle) begin
        m_idle = 1'b0; t = 0; m_cs = cs_in; m_md = mode; k = seq_len(16, cs_in[1]);
      end else begin
        t++;
        if (t == k + 2) m_idle = 1'b1;
      end
      @(negedge clk);
    end
    start_valid = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    mode = 1'b0; cs_in = 2'b00;
    test_reset();
    test_circular();
    test_hyperbolic();
    test_done_hold();
    test_random_ops();
    test_abort_iter();
    test_abort_with_start();
    test_abort_in_done();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
